// File: rtl/pea_ctrl.sv
// pea_ctrl: conv-tile sequencer for the PE array (weight load, ifm window fill, streamed compute).
// Optional perf counters are built in when PEA_CTRL_PERF_EN is defined.
module pea_ctrl #(
    parameter int COL    = 8,
    parameter int KH     = 3,
    parameter int PE_LAT = 2,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic [CNT_W-1:0] cfg_oc_num,
    input  logic [CNT_W-1:0] cfg_ic_num,
    input  logic [CNT_W-1:0] cfg_oh,
    input  logic             cfg_stride,
    input  logic             wgt_avail,
    input  logic             ifm_avail,
    output logic             stride,
    output logic             wgt_read,
    output logic             ifm_read,
    output logic [COL-1:0]   pvalid,
    output logic             ic_done,
    output logic             oc_done,
    output logic             busy,
    output logic             done,
`ifdef PEA_CTRL_PERF_EN
    output logic [31:0]      perf_busy_cyc,
    output logic [31:0]      perf_stall_cyc,
`endif
    output logic [2:0]       dbg_state
);

    localparam int KW = $clog2(KH + 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WLOAD = 3'd1,
        IFILL = 3'd2,
        COMP  = 3'd3,
        DRAIN = 3'd4
    } state_t;

    // Handshake: wgt_read/ifm_read are single-cycle pops, one cycle after avail was seen
    // high in the corresponding state; the source must hold a row whenever avail is high.
    state_t           state_q, state_d;
    logic             stride_q, stride_d;
    logic [CNT_W-1:0] oc_num_q, oc_num_d;
    logic [CNT_W-1:0] ic_num_q, ic_num_d;
    logic [CNT_W-1:0] oh_q, oh_d;
    logic [KW-1:0]    kcnt_q, kcnt_d;
    logic             sub_q, sub_d;
    logic [CNT_W:0]   row_q, row_d;
    logic [CNT_W:0]   ic_q, ic_d;
    logic [CNT_W:0]   oc_q, oc_d;
    logic             wgt_read_q, wgt_read_d;
    logic             ifm_read_q, ifm_read_d;
    logic             ic_done_q, ic_done_d;
    logic             oc_done_q, oc_done_d;
    logic             done_q, done_d;
    logic             busy_q;
    logic [PE_LAT:0]  sr_q;
    logic             inject;
    logic             accept;

    assign accept = (state_q == IDLE) && start;

    always_comb begin
        state_d    = state_q;
        stride_d   = stride_q;
        oc_num_d   = oc_num_q;
        ic_num_d   = ic_num_q;
        oh_d       = oh_q;
        kcnt_d     = kcnt_q;
        sub_d      = sub_q;
        row_d      = row_q;
        ic_d       = ic_q;
        oc_d       = oc_q;
        wgt_read_d = 1'b0;
        ifm_read_d = 1'b0;
        ic_done_d  = 1'b0;
        oc_done_d  = 1'b0;
        done_d     = 1'b0;
        inject     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    stride_d = cfg_stride;
                    oc_num_d = cfg_oc_num;
                    ic_num_d = cfg_ic_num;
                    oh_d     = cfg_oh;
                    kcnt_d   = '0;
                    sub_d    = 1'b0;
                    row_d    = '0;
                    ic_d     = '0;
                    oc_d     = '0;
                    if ((cfg_oc_num == '0) || (cfg_ic_num == '0) || (cfg_oh == '0)) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = WLOAD;
                    end
                end
            end
            WLOAD: begin
                if (wgt_avail) begin
                    wgt_read_d = 1'b1;
                    if (kcnt_q == KW'(KH - 1)) begin
                        kcnt_d  = '0;
                        state_d = IFILL;
                    end else begin
                        kcnt_d = kcnt_q + 1'b1;
                    end
                end
            end
            IFILL: begin
                if (ifm_avail) begin
                    ifm_read_d = 1'b1;
                    if (kcnt_q == KW'(KH - 1)) begin
                        // The completed window is output row 0 of the pass.
                        kcnt_d  = '0;
                        inject  = 1'b1;
                        sub_d   = 1'b0;
                        row_d   = {{CNT_W{1'b0}}, 1'b1};
                        state_d = (oh_q == {{(CNT_W-1){1'b0}}, 1'b1}) ? DRAIN : COMP;
                    end else begin
                        kcnt_d = kcnt_q + 1'b1;
                    end
                end
            end
            COMP: begin
                if (ifm_avail) begin
                    ifm_read_d = 1'b1;
                    if (sub_q == stride_q) begin
                        sub_d  = 1'b0;
                        inject = 1'b1;
                        row_d  = row_q + 1'b1;
                        if ((row_q + 1'b1) == {1'b0, oh_q}) begin
                            state_d = DRAIN;
                        end
                    end else begin
                        sub_d = 1'b1;
                    end
                end
            end
            DRAIN: begin
                // Only the stage feeding pvalid may still be set: that is the last beat.
                if (sr_q[PE_LAT-1:0] == '0) begin
                    ic_done_d = 1'b1;
                    row_d     = '0;
                    if ((ic_q + 1'b1) == {1'b0, ic_num_q}) begin
                        ic_d      = '0;
                        oc_done_d = 1'b1;
                        if ((oc_q + 1'b1) == {1'b0, oc_num_q}) begin
                            oc_d    = '0;
                            done_d  = 1'b1;
                            state_d = IDLE;
                        end else begin
                            oc_d    = oc_q + 1'b1;
                            state_d = WLOAD;
                        end
                    end else begin
                        ic_d    = ic_q + 1'b1;
                        state_d = WLOAD;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= IDLE;
            stride_q   <= 1'b0;
            oc_num_q   <= '0;
            ic_num_q   <= '0;
            oh_q       <= '0;
            kcnt_q     <= '0;
            sub_q      <= 1'b0;
            row_q      <= '0;
            ic_q       <= '0;
            oc_q       <= '0;
            wgt_read_q <= 1'b0;
            ifm_read_q <= 1'b0;
            ic_done_q  <= 1'b0;
            oc_done_q  <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            sr_q       <= '0;
        end else begin
            state_q    <= state_d;
            stride_q   <= stride_d;
            oc_num_q   <= oc_num_d;
            ic_num_q   <= ic_num_d;
            oh_q       <= oh_d;
            kcnt_q     <= kcnt_d;
            sub_q      <= sub_d;
            row_q      <= row_d;
            ic_q       <= ic_d;
            oc_q       <= oc_d;
            wgt_read_q <= wgt_read_d;
            ifm_read_q <= ifm_read_d;
            ic_done_q  <= ic_done_d;
            oc_done_q  <= oc_done_d;
            done_q     <= done_d;
            busy_q     <= (state_d != IDLE);
            sr_q       <= {sr_q[PE_LAT-1:0], inject};
        end
    end

`ifdef PEA_CTRL_PERF_EN
    logic [31:0] busy_cyc_q;
    logic [31:0] stall_cyc_q;
    logic        stall_now;

    assign stall_now = ((state_q == WLOAD) && !wgt_avail) ||
                       (((state_q == IFILL) || (state_q == COMP)) && !ifm_avail);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            busy_cyc_q  <= '0;
            stall_cyc_q <= '0;
        end else if (accept) begin
            busy_cyc_q  <= '0;
            stall_cyc_q <= '0;
        end else begin
            if (busy_q && (busy_cyc_q != '1)) begin
                busy_cyc_q <= busy_cyc_q + 1'b1;
            end
            if (stall_now && (stall_cyc_q != '1)) begin
                stall_cyc_q <= stall_cyc_q + 1'b1;
            end
        end
    end

    assign perf_busy_cyc  = busy_cyc_q;
    assign perf_stall_cyc = stall_cyc_q;
`else
    logic unused_accept;
    assign unused_accept = accept;
`endif

    assign stride    = stride_q;
    assign wgt_read  = wgt_read_q;
    assign ifm_read  = ifm_read_q;
    assign pvalid    = {COL{sr_q[PE_LAT]}};
    assign ic_done   = ic_done_q;
    assign oc_done   = oc_done_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_pea_ctrl.sv
// Directed bench for pea_ctrl: event monitor on the falling edge, checks on posedge+1.
// Perf counter checks are compiled in when PEA_CTRL_PERF_EN is defined.
module tb_pea_ctrl;
    localparam int COL   = 8;
    localparam int CNT_W = 8;

    logic             clk;
    logic             rstn;
    logic             start;
    logic [CNT_W-1:0] cfg_oc_num, cfg_ic_num, cfg_oh;
    logic             cfg_stride, wgt_avail, ifm_avail;
    logic             stride, wgt_read, ifm_read, ic_done, oc_done, busy, done;
    logic [COL-1:0]   pvalid;
    logic [2:0]       dbg_state;
`ifdef PEA_CTRL_PERF_EN
    logic [31:0]      perf_busy_cyc, perf_stall_cyc;
`endif

    pea_ctrl #(.COL(COL), .KH(3), .PE_LAT(2), .CNT_W(CNT_W)) dut (
        .clk(clk), .rstn(rstn), .start(start),
        .cfg_oc_num(cfg_oc_num), .cfg_ic_num(cfg_ic_num), .cfg_oh(cfg_oh),
        .cfg_stride(cfg_stride), .wgt_avail(wgt_avail), .ifm_avail(ifm_avail),
        .stride(stride), .wgt_read(wgt_read), .ifm_read(ifm_read), .pvalid(pvalid),
        .ic_done(ic_done), .oc_done(oc_done), .busy(busy), .done(done),
`ifdef PEA_CTRL_PERF_EN
        .perf_busy_cyc(perf_busy_cyc), .perf_stall_cyc(perf_stall_cyc),
`endif
        .dbg_state(dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Event monitor: counts and time-stamps DUT strobes on the falling edge.
    logic mon_clr = 1'b0;
    int cyc = 0;
    int t_st, n_wr, n_ir, n_pv, n_badpv, n_icd, n_ocd, n_done, n_busy;
    int t_ir1, t_ir3, t_irl, t_pv1, t_pvl, t_icd, t_ocd, t_done;
    logic [7:0] ocd_q[$];
    logic [7:0] exp_q[$];

    always @(negedge clk) begin
        cyc++;
        if (mon_clr) begin
            t_st = 0; n_wr = 0; n_ir = 0; n_pv = 0; n_badpv = 0; n_icd = 0; n_ocd = 0;
            n_done = 0; n_busy = 0; t_ir1 = 0; t_ir3 = 0; t_irl = 0; t_pv1 = 0; t_pvl = 0;
            t_icd = 0; t_ocd = 0; t_done = -100;
            ocd_q.delete();
        end else begin
            if (start) t_st = cyc;
            if (wgt_read) n_wr++;
            if (ifm_read) begin
                n_ir++;
                if (n_ir == 1) t_ir1 = cyc;
                if (n_ir == 3) t_ir3 = cyc;
                t_irl = cyc;
            end
            if (pvalid != '0) begin
                n_pv++;
                if (pvalid !== {COL{1'b1}}) n_badpv++;
                if (n_pv == 1) t_pv1 = cyc;
                t_pvl = cyc;
            end
            if (ic_done) begin
                n_icd++;
                t_icd = cyc;
            end
            if (oc_done) begin
                n_ocd++;
                t_ocd = cyc;
                ocd_q.push_back(8'(n_icd));
            end
            if (done) begin
                n_done++;
                t_done = cyc;
            end
            if (busy) n_busy++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clr_mon();
        mon_clr = 1'b1;
        step(1);
        mon_clr = 1'b0;
    endtask

    task automatic start_cmd(input int oc, input int ic, input int oh, input logic s);
        cfg_oc_num = CNT_W'(oc);
        cfg_ic_num = CNT_W'(ic);
        cfg_oh     = CNT_W'(oh);
        cfg_stride = s;
        start      = 1'b1;
        step(1);
        start      = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int i = 0;
        while (n_done == 0 && i < budget) begin
            step(1);
            i++;
        end
        chk("done_within_budget", (n_done != 0), 1);
        step(3);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk(tag, {stride, wgt_read, ifm_read, ic_done, oc_done, busy, done}, 0);
        chk({tag, "_pvalid"}, pvalid, 0);
    endtask

    initial begin
        rstn = 1'b0; start = 1'b0; cfg_oc_num = '0; cfg_ic_num = '0; cfg_oh = '0;
        cfg_stride = 1'b0; wgt_avail = 1'b1; ifm_avail = 1'b1;
        step(3);
        chk_outputs_zero("reset_outputs");
        chk("reset_state", dbg_state, 0);
        rstn = 1'b1;
        step(2);

        // 1: single pass, oh=4, stride 1 (cfg 0)
        clr_mon();
        start_cmd(1, 1, 4, 1'b0);
        chk("t1_busy_next_cycle", busy, 1);
        wait_done(100);
        chk("t1_wgt_reads", n_wr, 3);
        chk("t1_ifm_reads", n_ir, 6);
        chk("t1_ifm_back_to_back", t_irl - t_ir1, 5);
        chk("t1_pvalid_beats", n_pv, 4);
        chk("t1_pvalid_all_ones", n_badpv, 0);
        chk("t1_pvalid_latency", t_pv1 - t_ir3, 2);
        chk("t1_icdone_after_last_pv", t_icd - t_pvl, 1);
        chk("t1_ocdone_with_icdone", t_ocd - t_icd, 0);
        chk("t1_done_with_icdone", t_done - t_icd, 0);
        chk("t1_done_count", n_done, 1);
        chk("t1_busy_cycles", n_busy, 12);

        // 2: oc=2, ic=3, oh=2, stride 2
        clr_mon();
        start_cmd(2, 3, 2, 1'b1);
        chk("t2_stride_reg", stride, 1);
        wait_done(400);
        chk("t2_pvalid_beats", n_pv, 12);
        chk("t2_ic_done", n_icd, 6);
        chk("t2_oc_done", n_ocd, 2);
        exp_q = '{8'd3, 8'd6};
        chk("t2_ocd_count", ocd_q.size(), exp_q.size());
        while (exp_q.size() != 0 && ocd_q.size() != 0) begin
            chk("t2_ocd_on_ic_index", ocd_q.pop_front(), exp_q.pop_front());
        end
        chk("t2_ifm_reads", n_ir, 30);
        chk("t2_wgt_reads", n_wr, 18);
        chk("t2_done_count", n_done, 1);

        // 3: ifm_avail 1010 during COMP (cycles 7..10 after start)
        clr_mon();
        cfg_oc_num = 8'd1; cfg_ic_num = 8'd1; cfg_oh = 8'd4; cfg_stride = 1'b0;
        start = 1'b1;
        step(1);
        start = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            ifm_avail = (k == 8 || k == 10) ? 1'b0 : 1'b1;
            step(1);
        end
        ifm_avail = 1'b1;
        wait_done(50);
        chk("t3_ifm_reads", n_ir, 6);
        chk("t3_ifm_read_span", t_irl - t_ir1, 7);
        chk("t3_pvalid_beats", n_pv, 4);
        chk("t3_pvalid_latency", t_pv1 - t_ir3, 2);
        chk("t3_done_time", t_done - t_st, 15);
        chk("t3_busy_cycles", n_busy, 14);
`ifdef PEA_CTRL_PERF_EN
        chk("t6_perf_stall", perf_stall_cyc, 2);
        chk("t6_perf_busy", perf_busy_cyc, 14);
`endif

        // 4: zero input-channel count
        clr_mon();
        start_cmd(2, 0, 3, 1'b0);
        step(4);
        chk("t4_done_one_cycle", t_done - t_st, 1);
        chk("t4_strobes", n_wr + n_ir + n_pv, 0);
        chk("t4_busy_stays_low", n_busy, 0);

        // 5a: start re-pulsed while busy with a different oh
        clr_mon();
        start_cmd(1, 1, 4, 1'b0);
        step(2);
        cfg_oh = 8'd8;
        start  = 1'b1;
        step(1);
        start  = 1'b0;
        wait_done(100);
        chk("t5_restart_ignored_pv", n_pv, 4);
        chk("t5_restart_ignored_ir", n_ir, 6);
        chk("t5_restart_done", n_done, 1);

        // 5b: reset during COMP, then a clean rerun
        clr_mon();
        start_cmd(1, 1, 4, 1'b1);
        step(7);
        chk("t5_in_comp", dbg_state, 3);
        rstn = 1'b0;
        step(1);
        chk_outputs_zero("t5_abort_outputs");
        rstn = 1'b1;
        step(20);
        chk("t5_abort_no_done", n_done + n_icd + n_ocd, 0);
        chk("t5_abort_pv_dropped", n_pv, 0);
        clr_mon();
        start_cmd(1, 1, 4, 1'b0);
        wait_done(100);
        chk("t5_rerun_pv", n_pv, 4);
        chk("t5_rerun_ir", n_ir, 6);
        chk("t5_rerun_done_time", t_done - t_st, 13);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
